// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//
// Read-side sequencer for the SRAM emulator's read-only port. A start command
// walks a contiguous address range and drives one read address per cycle. The
// SRAM's one-cycle registered read latency is absorbed by a two-stage tag
// pipeline. Words are delivered in order on a valid/ready stream through a
// small FIFO. Issue is credit-limited, so stalls never drop or duplicate words.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle command strobe, sampled only in IDLE
//   base_addr   first address, sampled with start
//   length      word count 0..2^AW, sampled with start
//   abort       synchronous flush, highest priority after reset
//   busy        high while a block is in progress
//   done        one-cycle completion pulse
//   sram_raddr  registered read address to the SRAM
//   sram_rdata  SRAM read data, valid one clock after the address edge
//   out_data    stream data (FIFO head, zero when empty)
//   out_valid   stream valid
//   out_ready   stream ready
module sram_stream_reader #(
  parameter int AW         = 18,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic              state_reg;
  logic [AW-1:0]     addr_reg;
  logic [AW-1:0]     sram_raddr_reg;
  logic [AW:0]       issue_left_reg;
  logic [AW:0]       deliver_left_reg;
  logic              p1_reg;
  logic              p2_reg;
  logic              done_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     fifo_count_reg;
  logic [DW-1:0]     fifo_mem [FIFO_DEPTH];

  logic              push;
  logic              pop;
  logic [CW:0]       inflight;
  logic              credit_ok;
  logic              issue;

  // A word tagged in p2 is sitting on sram_rdata this cycle; an abort discards it.
  assign push = p2_reg & ~abort;
  assign pop  = out_valid & out_ready;

  // Reads in flight (p1, p2) already own a FIFO slot. Counting them before a new
  // issue makes overflow impossible, whatever the consumer does.
  assign inflight  = {1'b0, fifo_count_reg}
                   + {{CW{1'b0}}, p1_reg}
                   + {{CW{1'b0}}, p2_reg};
  assign credit_ok = inflight < (CW+1)'(FIFO_DEPTH);
  assign issue     = (state_reg == ST_RUN) && !abort
                   && (issue_left_reg != '0) && credit_ok;

  assign busy       = (state_reg == ST_RUN);
  assign done       = done_reg;
  assign sram_raddr = sram_raddr_reg;
  assign out_valid  = (fifo_count_reg != '0);
  // Gate the head with valid so out_data reads zero when empty, including
  // immediately on reset when the storage itself is not cleared.
  assign out_data   = out_valid ? fifo_mem[rd_ptr_reg] : '0;

  // FIFO storage: plain registers without reset, written by the pipeline tail.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      sram_raddr_reg   <= '0;
      issue_left_reg   <= '0;
      deliver_left_reg <= '0;
      p1_reg           <= 1'b0;
      p2_reg           <= 1'b0;
      done_reg         <= 1'b0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      fifo_count_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      p2_reg   <= p1_reg;
      p1_reg   <= 1'b0;

      if (abort) begin
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        fifo_count_reg <= '0;
        p1_reg         <= 1'b0;
        p2_reg         <= 1'b0;
        if (state_reg == ST_RUN) begin
          state_reg        <= ST_IDLE;
          issue_left_reg   <= '0;
          deliver_left_reg <= '0;
          done_reg         <= 1'b1;
        end
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
          2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
          2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
          default: fifo_count_reg <= fifo_count_reg;
        endcase

        if (state_reg == ST_IDLE) begin
          if (start) begin
            if (length == '0) begin
              done_reg <= 1'b1;
            end else begin
              // The first read goes out on the same edge that accepts the
              // command, so addr/issue_left are loaded already advanced by one.
              state_reg        <= ST_RUN;
              sram_raddr_reg   <= base_addr;
              addr_reg         <= base_addr + AW'(1);
              issue_left_reg   <= length - (AW+1)'(1);
              deliver_left_reg <= length;
              p1_reg           <= 1'b1;
            end
          end
        end else begin
          if (issue) begin
            sram_raddr_reg <= addr_reg;
            addr_reg       <= addr_reg + AW'(1);  // wraps modulo 2^AW
            issue_left_reg <= issue_left_reg - (AW+1)'(1);
            p1_reg         <= 1'b1;
          end
          if (pop) begin
            deliver_left_reg <= deliver_left_reg - (AW+1)'(1);
            if (deliver_left_reg == (AW+1)'(1)) begin
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
      end
    end
  end

  // The credit rule must keep the FIFO from ever being pushed while full.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (fifo_count_reg == CW'(FIFO_DEPTH))));
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
module tb_sram_stream_reader;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [DW-1:0] sb_q[$];
  bit stall_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  sram_stream_reader #(.AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // SRAM model: mem[a] = a[15:0], one-cycle registered read.
  always @(posedge clk) sram_rdata <= sram_raddr[DW-1:0];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor: every valid cycle the head must equal the oldest expected
  // word, which also proves stability while stalled.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check_val("sb_has_word", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() != 0) begin
        check_val("stream_data", {16'h0, out_data}, {16'h0, sb_q[0]});
        $display("word 0x%04h ready=%0d", out_data, out_ready);
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic push_expected(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    for (int k = 0; k < len; k++) begin
      a = base + AW'(k);
      sb_q.push_back(a[DW-1:0]);
    end
  endtask

  task automatic run_read(input logic [AW-1:0] base, input int len, input int exp_done, input bit stall);
    int n;
    int first_valid;
    logic [AW-1:0] a;
    first_valid = -1;
    push_expected(base, len);
    base_addr = base;
    length = (AW+1)'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    check_val("busy_after_start", {31'h0, busy}, 32'd1);
    while (!done && n < 200) begin
      if (out_valid && first_valid < 0) first_valid = n;
      if (!stall && n < len) begin
        a = base + AW'(n);
        check_val("issue_addr", {14'h0, sram_raddr}, {14'h0, a});
      end
      if (stall) out_ready = stall_pat[n % 5];
      tick();
      n++;
    end
    check_val("done_seen", {31'h0, done}, 32'd1);
    check_val("first_valid_latency", first_valid, 32'd2);
    if (exp_done >= 0) check_val("done_cycle", n, exp_done);
    check_val("busy_at_done", {31'h0, busy}, 32'd0);
    out_ready = 1'b1;
    tick();
    check_val("done_one_cycle", {31'h0, done}, 32'd0);
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("read base=0x%05h len=%0d finished after %0d cycles", base, len, n);
  endtask

  initial begin
    // Reset state
    tick();
    check_val("rst_busy", {31'h0, busy}, 32'd0);
    check_val("rst_done", {31'h0, done}, 32'd0);
    check_val("rst_valid", {31'h0, out_valid}, 32'd0);
    check_val("rst_raddr", {14'h0, sram_raddr}, 32'd0);
    check_val("rst_data", {16'h0, out_data}, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Basic 8-word read, no stalls
    run_read(18'h00010, 8, 10, 1'b0);
    // Same read under back-pressure
    run_read(18'h00010, 8, -1, 1'b1);
    // Address wrap
    run_read(18'h3FFFE, 4, 6, 1'b0);

    // length = 0: no reads, done next cycle
    base_addr = 18'h00100;
    length = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("len0_done", {31'h0, done}, 32'd1);
    check_val("len0_busy", {31'h0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_val("len0_raddr", {14'h0, sram_raddr}, 32'h00001);
      check_val("len0_valid", {31'h0, out_valid}, 32'd0);
      tick();
      check_val("len0_done_once", {31'h0, done}, 32'd0);
    end
    $display("len0 command finished");

    // Abort in the third cycle of an 8-word read
    push_expected(18'h00010, 8);
    base_addr = 18'h00010;
    length = 19'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_valid", {31'h0, out_valid}, 32'd0);
    check_val("abort_done", {31'h0, done}, 32'd1);
    check_val("abort_busy", {31'h0, busy}, 32'd0);
    sb_q.delete();
    tick();
    check_val("abort_done_once", {31'h0, done}, 32'd0);
    check_val("abort_valid_after", {31'h0, out_valid}, 32'd0);
    $display("abort issued");
    run_read(18'h00100, 2, 4, 1'b0);

    // Asynchronous reset mid-transfer
    push_expected(18'h00200, 8);
    base_addr = 18'h00200;
    length = 19'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", {31'h0, busy}, 32'd0);
    check_val("arst_done", {31'h0, done}, 32'd0);
    check_val("arst_valid", {31'h0, out_valid}, 32'd0);
    check_val("arst_raddr", {14'h0, sram_raddr}, 32'd0);
    check_val("arst_data", {16'h0, out_data}, 32'd0);
    sb_q.delete();
    $display("async reset applied");
    tick();
    #2 rst_n = 1'b1;
    tick();
    run_read(18'h00010, 3, 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sram_stream_reader.md
# sram_stream_reader

Read-side sequencer placed directly upstream of the SRAM emulator's read-only port. On a start command it walks a contiguous address range and drives `sram_raddr` once per cycle. It absorbs the SRAM's one-cycle registered read latency and delivers the words in order on a valid/ready stream with back-pressure. No word is dropped or duplicated when the consumer stalls.

## Interface
- `AW`, 18, SRAM address width; must match the SRAM.
- `DW`, 16, SRAM data width.
- `FIFO_DEPTH`, 4, output buffer entries, power of two, ≥2. A value ≥4 is required for one word per cycle.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle command strobe; sampled only in IDLE.
- `base_addr`  in  AW  first address; sampled with `start`.
- `length`  in  AW+1  word count, 0..2^AW; sampled with `start`.
- `abort`  in  1  synchronous flush; highest priority after reset.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `sram_raddr`  out  AW  to SRAM `raddr`; registered.
- `sram_rdata`  in  DW  from SRAM `rdata`; valid one clock after the address edge.
- `out_data`  out  DW  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.

## Operation
- States are IDLE and RUN.
- Registered state:
  - `addr` (AW) and `issue_left` (AW+1).
  - `deliver_left` (AW+1).
  - Pipeline tags `p1` and `p2`: a read was issued last edge, and `sram_rdata` holds a requested word, respectively.
  - FIFO pointers and `fifo_count`.
- IDLE:
  - `start=1` and `length≠0`: load `addr=base_addr`, `issue_left=deliver_left=length`, go to RUN.
  - `start=1` and `length=0`: stay in IDLE and pulse `done` next cycle; no reads are issued.
- RUN, issue rule: at each edge where `issue_left≠0` and `fifo_count+p1+p2 < FIFO_DEPTH`:
  - `sram_raddr<=addr`, `addr<=addr+1` (mod 2^AW, so it wraps from 2^AW−1 to 0).
  - `issue_left` decrements and `p1<=1`; otherwise `p1<=0`.
  - `sram_raddr` holds its last value when not issuing.
  - The first issue happens at the same edge that samples `start`.
- Pipeline: `p2<=p1` every edge. When `p2=1`, `sram_rdata` is written into the FIFO at that edge.
- The credit rule guarantees no FIFO overflow. An overflow is an assertion failure.
- Stream:
  - `out_valid = (fifo_count≠0)`; `out_data` is the FIFO head.
  - A pop happens when `out_valid & out_ready`; each pop decrements `deliver_left`.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - `out_data` is stable while `out_valid & ~out_ready`.
- Completion: the pop that takes `deliver_left` from 1 to 0 sends the block to IDLE, with `done=1` the following cycle.
- `start` while in RUN is ignored.
- `abort`:
  - In RUN: clears the FIFO, `p1`, `p2` and the counters, goes to IDLE and pulses `done` the next cycle.
  - In IDLE: clears the FIFO and has no other effect.
  - `abort` together with `start` in IDLE: `abort` wins and the command is dropped.
- Reset values: state IDLE; `busy`, `done`, `out_valid`, `p1`, `p2` and `fifo_count` all 0; `sram_raddr` 0; `out_data` 0.

## Timing
- Let E0 be the edge that samples `start`.
- Word *k* (from 0, consumer always ready):
  - `sram_raddr=base_addr+k` after edge E0+k.
  - Data is on `sram_rdata` after E1+k.
  - `out_valid` is high with `out_data=mem[base_addr+k]` after E2+k.
- Throughput is 1 word/cycle with `FIFO_DEPTH≥4` and `out_ready=1`.
- Latency from the start edge to the first `out_valid` is 2 cycles.
- With `length=N` and no stalls:
  - the last pop is in cycle E(N+1);
  - `busy` is high from after E0 through after E(N+1);
  - `done` is high after E(N+2) for one cycle, with `busy=0`.
- Back-pressure: once `out_ready` is low, issuing stops within 1 cycle. At most FIFO_DEPTH words are buffered.

## Test plan
- SRAM preloaded with `mem[a]=a[15:0]`; `base=0x00010`, `length=8`, `out_ready=1`: the stream outputs 0x0010..0x0017 on consecutive cycles, the first 2 cycles after start, and `done` pulses once.
- Same read with `out_ready` toggling 1,0,0,1,0,…: the stream is still 0x0010..0x0017 in order, with no duplicates and no data change while stalled. `fifo_count` never exceeds 4.
- Wrap: `base=0x3FFFE`, `length=4`: the addresses issued are 0x3FFFE, 0x3FFFF, 0x00000, 0x00001, and the stream data matches.
- `length=0`: no change on `sram_raddr`, `out_valid` stays 0, and `done` goes high the cycle after start.
- `abort` in the third cycle of an 8-word read: `out_valid` is 0 the next cycle, and `done` pulses. A following start with `base=0x100`, `length=2` yields 0x0100, 0x0101 only.
- `rst_n` pulled low asynchronously mid-transfer: all outputs go to 0 immediately, without waiting for a clock edge. After release, a new 3-word read behaves as in the first scenario.
